noc_ingress_buffer: RTL and testbench



---
 rtl/noc_pkg.sv | 20 ++
 rtl/noc_fifo_mem.sv | 27 ++
 rtl/noc_ingress_buffer.sv | 93 +++++++++
 tb/tb_noc_ingress_buffer.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit layout and field positions.
package noc_pkg;

  localparam int FLIT_W   = 16;
  localparam int VLD_BIT  = 0;
  localparam int DEST_LSB = 1;
  localparam int SRC_LSB  = 3;
  localparam int SEQ_LSB  = 5;
  localparam int NODE_W   = 2;
  localparam int SEQ_W    = FLIT_W - SEQ_LSB;

  // Flit as seen by router and sink blocks; bit 0 is the valid flag
  typedef struct packed {
    logic [SEQ_W-1:0]  seq;
    logic [NODE_W-1:0] src;
    logic [NODE_W-1:0] dest;
    logic              vld;
  } flit_t;

endpackage

// File: rtl/noc_fifo_mem.sv
// Flit storage: one synchronous write port, one combinational read port.
module noc_fifo_mem #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Storage array has no reset; validity is tracked by the pointer logic
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  // Read is combinational so the head flit falls through immediately
  always_comb begin
    rdata = mem_q[raddr];
  end

endmodule

// File: rtl/noc_ingress_buffer.sv
// Per-port ingress FIFO between a node writer and the router crossbar.
// DEPTH must equal 2**ADDR_WIDTH so pointers wrap naturally.
module noc_ingress_buffer #(
  parameter int DATA_WIDTH = noc_pkg::FLIT_W,
  parameter int DEPTH      = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  write,
  input  logic [DATA_WIDTH-1:0] dataIn,
  output logic                  full,
  output logic                  almost_full,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [1:0]            out_dest,
  output logic [ADDR_WIDTH:0]   occupancy,
  output logic                  drop_invalid,
  output logic                  overflow
);
  import noc_pkg::*;

  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  drop_invalid_q, drop_invalid_d;
  logic                  overflow_q, overflow_d;
  logic                  push_ok, pop_ok;

  // Status flags come from registered state only
  always_comb begin
    full         = (count_q == DEPTH_C);
    almost_full  = (count_q >= DEPTH_C - (ADDR_WIDTH+1)'(1));
    out_valid    = (count_q != '0);
    occupancy    = count_q;
    out_dest     = out_data[DEST_LSB +: NODE_W];
    drop_invalid = drop_invalid_q;
    overflow     = overflow_q;
  end

  // Next-state: invalid flits are dropped before the full check; a pop
  // in the same cycle never frees room for a push into a full buffer
  always_comb begin
    push_ok        = write && dataIn[VLD_BIT] && !full;
    pop_ok         = out_valid && out_ready;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    count_d        = count_q;
    drop_invalid_d = write && !dataIn[VLD_BIT];
    overflow_d     = overflow_q | (write && dataIn[VLD_BIT] && full);
    if (push_ok) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (ADDR_WIDTH+1)'(1);
      2'b01:   count_d = count_q - (ADDR_WIDTH+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      drop_invalid_q <= 1'b0;
      overflow_q     <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      drop_invalid_q <= drop_invalid_d;
      overflow_q     <= overflow_d;
    end
  end

  noc_fifo_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_mem (
    .clk  (clk),
    .we   (push_ok),
    .waddr(wr_ptr_q),
    .wdata(dataIn),
    .raddr(rd_ptr_q),
    .rdata(out_data)
  );

endmodule

// File: tb/tb_noc_ingress_buffer.sv
// Randomized bench for noc_ingress_buffer against a queue-based reference.
module tb_noc_ingress_buffer;
  import noc_pkg::*;

  localparam int DW = 16;
  localparam int DEPTH = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          write = 1'b0;
  logic [DW-1:0] dataIn = '0;
  logic          full, almost_full, out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [1:0]    out_dest;
  logic [AW:0]   occupancy;
  logic          drop_invalid, overflow;

  int checks = 0;
  int errors = 0;

  // Reference: list of stored flits plus the two status bits
  logic [DW-1:0] q[$];
  logic          m_ovf = 1'b0;
  logic          m_drop = 1'b0;

  noc_ingress_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .write(write), .dataIn(dataIn),
    .full(full), .almost_full(almost_full), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_dest(out_dest),
    .occupancy(occupancy), .drop_invalid(drop_invalid), .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mk(input int seq, input int src, input int dest, input bit v);
    flit_t f;
    f.seq = SEQ_W'(seq); f.src = NODE_W'(src); f.dest = NODE_W'(dest); f.vld = v;
    return f;
  endfunction

  // Advance the reference by the rules for one edge, then take the edge
  task automatic tick();
    logic was_full;
    if (reset) begin
      q.delete(); m_ovf = 1'b0; m_drop = 1'b0;
    end else begin
      was_full = (q.size() == DEPTH);
      m_drop = write && !dataIn[0];
      if (write && dataIn[0] && was_full) m_ovf = 1'b1;
      if (q.size() != 0 && out_ready) q.delete(0);
      if (write && dataIn[0] && !was_full) q.push_back(dataIn);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1; write = 0; out_ready = 0;
    tick(); reset = 0;
    checks++; if (occupancy !== 0) begin errors++; $display("FAIL reset_occ got %0d want 0", occupancy); end
    checks++; if ({full, almost_full, out_valid} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {full, almost_full, out_valid}); end
    checks++; if ({overflow, drop_invalid} !== 2'b00) begin errors++; $display("FAIL reset_sticky got %b want 00", {overflow, drop_invalid}); end
  endtask

  task automatic test_single();
    write = 1; dataIn = 16'h00A3; out_ready = 0;
    tick(); write = 0;
    checks++; if (out_valid !== 1'b1 || out_data !== 16'h00A3) begin errors++; $display("FAIL single_head got v=%b d=%h want v=1 d=00a3", out_valid, out_data); end
    checks++; if (out_dest !== 2'd1 || occupancy !== 1) begin errors++; $display("FAIL single_dest_occ got dest=%0d occ=%0d want 1 1", out_dest, occupancy); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (out_valid !== 1'b1 || out_data !== 16'h00A3) begin errors++; $display("FAIL single_hold got v=%b d=%h want v=1 d=00a3", out_valid, out_data); end
    end
    out_ready = 1; tick(); out_ready = 0;
    checks++; if (out_valid !== 1'b0 || occupancy !== 0) begin errors++; $display("FAIL single_pop got v=%b occ=%0d want 0 0", out_valid, occupancy); end
  endtask

  task automatic test_fill_overflow();
    out_ready = 0;
    for (int i = 0; i < DEPTH; i++) begin
      write = 1; dataIn = mk(i, $urandom_range(0, 3), $urandom_range(0, 3), 1);
      tick();
      checks++;
      if (occupancy !== q.size() || almost_full !== (q.size() >= DEPTH-1) || full !== (q.size() == DEPTH)) begin
        errors++; $display("FAIL fill_flags i=%0d got occ=%0d af=%b f=%b want occ=%0d", i, occupancy, almost_full, full, q.size());
      end
    end
    checks++; if (occupancy !== 32 || full !== 1'b1) begin errors++; $display("FAIL fill_full got occ=%0d f=%b want 32 1", occupancy, full); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fill_no_ovf got %b want 0", overflow); end
    // 33rd write while full, with a simultaneous pop that must not help
    dataIn = mk(99, 0, 0, 1); out_ready = 1;
    tick(); write = 0; out_ready = 0;
    checks++; if (overflow !== 1'b1 || occupancy !== 31) begin errors++; $display("FAIL ovf_set got ovf=%b occ=%0d want 1 31", overflow, occupancy); end
    // Refill the slot freed by that pop so the drain starts from full
    write = 1; dataIn = mk(32, 1, 2, 1); tick(); write = 0;
    checks++; if (occupancy !== 32 || overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got occ=%0d ovf=%b want 32 1", occupancy, overflow); end
  endtask

  task automatic test_drain();
    logic [DW-1:0] exp;
    out_ready = 1;
    for (int i = 0; i < DEPTH; i++) begin
      exp = q[0];
      checks++; if (out_valid !== 1'b1 || out_data !== exp || out_dest !== exp[2:1]) begin errors++; $display("FAIL drain_order i=%0d got %h want %h", i, out_data, exp); end
      tick();
      checks++; if (full !== 1'b0 || occupancy !== q.size()) begin errors++; $display("FAIL drain_occ i=%0d got occ=%0d f=%b want %0d 0", i, occupancy, full, q.size()); end
    end
    out_ready = 0;
    checks++; if (out_valid !== 1'b0 || occupancy !== 0) begin errors++; $display("FAIL drain_empty got v=%b occ=%0d want 0 0", out_valid, occupancy); end
  endtask

  task automatic test_stream();
    reset = 1; tick(); reset = 0;
    out_ready = 1;
    for (int s = 0; s < 45; s++) begin
      write = 1; dataIn = mk(s + 100, $urandom_range(0, 3), $urandom_range(0, 3), 1);
      tick();
      checks++;
      if (occupancy !== 1 || out_data[15:5] !== 11'(s + 100) || out_data !== q[0]) begin
        errors++; $display("FAIL stream s=%0d got occ=%0d seq=%0d want 1 %0d", s, occupancy, out_data[15:5], s + 100);
      end
    end
    write = 0; tick(); out_ready = 0;
    checks++; if (occupancy !== 0 || overflow !== 1'b0) begin errors++; $display("FAIL stream_end got occ=%0d ovf=%b want 0 0", occupancy, overflow); end
  endtask

  task automatic test_drop();
    write = 1; dataIn = 16'h00A2; out_ready = 0;
    tick(); write = 0;
    checks++; if (drop_invalid !== 1'b1 || occupancy !== 0 || out_valid !== 1'b0) begin errors++; $display("FAIL drop_pulse got d=%b occ=%0d v=%b want 1 0 0", drop_invalid, occupancy, out_valid); end
    tick();
    checks++; if (drop_invalid !== 1'b0) begin errors++; $display("FAIL drop_clear got %b want 0", drop_invalid); end
  endtask

  task automatic test_reset_mid();
    out_ready = 0;
    for (int i = 0; i < 10; i++) begin write = 1; dataIn = mk(i, 2, 3, 1); tick(); end
    write = 0;
    checks++; if (occupancy !== 10) begin errors++; $display("FAIL mid_pre got %0d want 10", occupancy); end
    reset = 1; tick(); reset = 0;
    checks++; if (occupancy !== 0 || out_valid !== 1'b0 || full !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL mid_reset got occ=%0d v=%b f=%b o=%b want all 0", occupancy, out_valid, full, overflow); end
    write = 1; dataIn = mk(7, 1, 1, 1); tick(); write = 0;
    checks++; if (out_valid !== 1'b1 || out_data !== mk(7, 1, 1, 1) || occupancy !== 1) begin errors++; $display("FAIL mid_after got v=%b d=%h occ=%0d", out_valid, out_data, occupancy); end
    out_ready = 1; tick(); out_ready = 0;
  endtask

  // Node model with a registered write that honours full/almost_full
  task automatic test_cpu();
    int seq_tx = 0, seq_rx = 0, errs_before = errors;
    logic w_prev = 0, af_prev = 0, f_prev = 0, next_w;
    for (int c = 0; c < 600; c++) begin
      next_w = ($urandom_range(0, 7) != 0);
      if (w_prev && af_prev) next_w = 0;
      if (!w_prev && f_prev) next_w = 0;
      write = next_w;
      dataIn = mk(seq_tx, 0, (seq_tx % 3) + 1, 1);
      out_ready = (c % 4 == 0);
      if (out_valid && out_ready) begin
        checks++;
        if (out_data[15:5] !== 11'(seq_rx) || out_data[4:3] !== 2'd0 || out_dest !== 2'((seq_rx % 3) + 1)) begin
          errors++; $display("FAIL cpu_rx got seq=%0d dest=%0d want seq=%0d dest=%0d", out_data[15:5], out_dest, seq_rx, (seq_rx % 3) + 1);
        end
        seq_rx++;
      end
      w_prev = write; af_prev = almost_full; f_prev = full;
      tick();
      if (w_prev) seq_tx++;
      if (occupancy !== q.size() && errors - errs_before < 5) begin
        checks++; errors++; $display("FAIL cpu_occ c=%0d got %0d want %0d", c, occupancy, q.size());
      end
    end
    write = 0; out_ready = 0;
    checks++; if (overflow !== 1'b0 || m_ovf !== 1'b0) begin errors++; $display("FAIL cpu_ovf got %b want 0", overflow); end
    checks++; if (seq_rx < 100) begin errors++; $display("FAIL cpu_progress got %0d flits want >=100", seq_rx); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_overflow();
    test_drain();
    test_stream();
    test_drop();
    test_reset_mid();
    test_cpu();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
